// File: rtl/inport_fifo.sv
// inport_fifo: strobe-edge capture of external words into a small FIFO for the In port.
// Ports: clock/clr (sync, active-high), ext_data/strobe in, rd_en pop, data_out/empty/full/count/ovf/drop_count out.
// Optional overflow tracking (ovf, drop_count) is enabled by defining INPORT_OVERFLOW_EN.
module inport_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clock,
  input  logic             clr,
  input  logic [WIDTH-1:0] ext_data,
  input  logic             strobe,
  input  logic             rd_en,
  output logic [WIDTH-1:0] data_out,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count,
  output logic             ovf,
  output logic [7:0]       drop_count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             strobe_q, strobe_d;

  logic push_req;
  logic do_pop;
  logic do_push;

  assign empty    = (count_q == '0);
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign count    = count_q;
  assign data_out = empty ? '0 : mem_q[rd_ptr_q];

  assign push_req = strobe & ~strobe_q;
  assign do_pop   = rd_en & ~empty;
  // A pop in the same edge frees a slot, so a full FIFO still accepts.
  assign do_push  = push_req & (~full | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    strobe_d = strobe;
    if (do_push) begin
      mem_d[wr_ptr_q] = ext_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  // Storage has no reset; only the pointers define validity.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clock) begin
    if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      // Reset high so a strobe held through reset does not capture.
      strobe_q <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      strobe_q <= strobe_d;
    end
  end

`ifdef INPORT_OVERFLOW_EN
  logic       dropped;
  logic       ovf_q, ovf_d;
  logic [7:0] drop_q, drop_d;

  assign dropped = push_req & full & ~do_pop;

  always_comb begin
    ovf_d  = ovf_q | dropped;
    drop_d = drop_q;
    if (dropped && drop_q != 8'hFF) begin
      drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (clr) begin
      ovf_q  <= 1'b0;
      drop_q <= 8'd0;
    end else begin
      ovf_q  <= ovf_d;
      drop_q <= drop_d;
    end
  end

  assign ovf        = ovf_q;
  assign drop_count = drop_q;
`else
  assign ovf        = 1'b0;
  assign drop_count = 8'd0;
`endif

endmodule

// File: tb/tb_inport_fifo.sv
// tb_inport_fifo: directed + random stimulus against a queue-based model.
// Expected ovf/drop_count follow INPORT_OVERFLOW_EN.
module tb_inport_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic             clock = 1'b0;
  logic             clr;
  logic [WIDTH-1:0] ext_data;
  logic             strobe;
  logic             rd_en;
  logic [WIDTH-1:0] data_out;
  logic             empty;
  logic             full;
  logic [AW:0]      count;
  logic             ovf;
  logic [7:0]       drop_count;

  inport_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clock(clock),
    .clr(clr),
    .ext_data(ext_data),
    .strobe(strobe),
    .rd_en(rd_en),
    .data_out(data_out),
    .empty(empty),
    .full(full),
    .count(count),
    .ovf(ovf),
    .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  logic [WIDTH-1:0] mq[$];
  logic             m_sprev;
  logic             m_ovf;
  int               m_drop;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic c, input logic s,
                       input logic [WIDTH-1:0] d, input logic r);
    bit push;
    if (c) begin
      mq.delete();
      m_sprev = 1'b1;
      m_ovf   = 1'b0;
      m_drop  = 0;
    end else begin
      push    = s && !m_sprev;
      m_sprev = s;
      if (r && mq.size() > 0) void'(mq.pop_front());
      if (push) begin
        if (mq.size() < DEPTH) mq.push_back(d);
        else begin
          m_ovf = 1'b1;
          if (m_drop < 255) m_drop++;
        end
      end
    end
  endtask

  task automatic check_all();
    logic [31:0] hd;
    hd = (mq.size() > 0) ? mq[0] : 32'd0;
    chk("data_out", data_out, hd);
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("full", 32'(full), 32'(mq.size() == DEPTH));
    chk("count", 32'(count), 32'(mq.size()));
`ifdef INPORT_OVERFLOW_EN
    chk("ovf", 32'(ovf), 32'(m_ovf));
    chk("drop_count", 32'(drop_count), 32'(m_drop));
`else
    chk("ovf", 32'(ovf), 32'd0);
    chk("drop_count", 32'(drop_count), 32'd0);
`endif
  endtask

  task automatic step(input logic c, input logic s,
                      input logic [WIDTH-1:0] d, input logic r);
    clr      = c;
    strobe   = s;
    ext_data = d;
    rd_en    = r;
    @(posedge clock);
    model(c, s, d, r);
    @(negedge clock);
    check_all();
  endtask

  task automatic pulse(input logic [WIDTH-1:0] d, input logic r);
    step(1'b0, 1'b1, d, r);
    step(1'b0, 1'b0, d, 1'b0);
  endtask

  initial begin
    clr = 1'b1; strobe = 1'b1; ext_data = '0; rd_en = 1'b0;
    mq.delete(); m_sprev = 1'b1; m_ovf = 1'b0; m_drop = 0;

    // 1: reset with strobe high, then no capture while it stays high
    step(1'b1, 1'b1, 32'h1111_1111, 1'b0);
    step(1'b1, 1'b1, 32'h1111_1111, 1'b0);
    chk("t1_empty", 32'(empty), 32'd1);
    step(1'b0, 1'b1, 32'h2222_2222, 1'b0);
    step(1'b0, 1'b1, 32'h2222_2222, 1'b0);
    chk("t1_nocap", 32'(count), 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b0);

    // 2: strobe held 4 cycles -> one capture
    step(1'b0, 1'b1, 32'hA5A5_0001, 1'b0);
    chk("t2_head", data_out, 32'hA5A5_0001);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'hA5A5_0001, 1'b0);
    chk("t2_count", 32'(count), 32'd1);
    step(1'b0, 1'b0, 32'h0, 1'b1);

    // 3: five words into depth four, then drain
    for (int i = 1; i <= 5; i++) pulse(32'(i), 1'b0);
    chk("t3_full", 32'(full), 32'd1);
    chk("t3_head", data_out, 32'd1);
    for (int i = 1; i <= 4; i++) begin
      chk("t3_seq", data_out, 32'(i));
      step(1'b0, 1'b0, 32'h0, 1'b1);
    end
    chk("t3_empty", 32'(empty), 32'd1);

    // 4: push and pop at full
    for (int i = 0; i < 4; i++) pulse(32'h40 + 32'(i), 1'b0);
    pulse(32'h4F, 1'b1);
    chk("t4_count", 32'(count), 32'd4);
    chk("t4_head", data_out, 32'h41);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

    // 5: pop while empty together with a push
    pulse(32'h0000_00C3, 1'b1);
    chk("t5_head", data_out, 32'h0000_00C3);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("t5_idle", 32'(count), 32'd0);

    // 6: ten push/pop pairs wrap the pointers, then clear at count 3
    pulse(32'h600, 1'b0);
    for (int i = 1; i <= 10; i++) pulse(32'h600 + 32'(i), 1'b1);
    for (int i = 0; i < 2; i++) pulse(32'h700 + 32'(i), 1'b0);
    chk("t6_count", 32'(count), 32'd3);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("t6_clr", 32'(empty), 32'd1);

    // random traffic with occasional clears
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 2) != 0),
           $urandom(),
           ($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
